// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the write-back port arbiter: FU result record, perf counter type,
// default sizing constants and small width/saturation helpers.
package wb_port_arbiter_pkg;

  localparam int unsigned NR_WB_REQ  = 3;
  localparam int unsigned WB_QDEPTH  = 2;
  localparam int unsigned PERF_CNT_W = 32;

  typedef logic [PERF_CNT_W-1:0] wb_arb_cnt_t;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  trans_id;
    logic        ex_valid;
  } fu_output_t;

  // Width of an index/pointer over n entries; never collapses to zero bits.
  function automatic int unsigned wb_arb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic wb_arb_cnt_t wb_arb_sat_inc(input wb_arb_cnt_t v);
    return (v == '1) ? v : v + wb_arb_cnt_t'(1'b1);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the per-FU result streams and the shared write-back slot.
// master = FU / WB-port side, slave = the arbiter.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ = NR_WB_REQ
);

  fu_output_t        req_i [NR_REQ];
  logic [NR_REQ-1:0] req_i_valid;
  logic [NR_REQ-1:0] req_i_ready;
  fu_output_t        wb_o;
  logic              wb_o_valid;
  logic              wb_o_ready;
  logic [NR_REQ-1:0] grant_o;

  modport master (
    output req_i, req_i_valid, wb_o_ready,
    input  req_i_ready, wb_o, wb_o_valid, grant_o
  );

  modport slave (
    input  req_i, req_i_valid, wb_o_ready,
    output req_i_ready, wb_o, wb_o_valid, grant_o
  );

endinterface

// File: rtl/wb_arb_fifo.sv
// Per-requester result FIFO: QDEPTH entries, synchronous flush, no fall-through.
// Push into a full FIFO and pop from an empty one are ignored.
module wb_arb_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned QDEPTH = WB_QDEPTH,
  parameter int unsigned QCNT_W = $clog2(QDEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic              push_i,
  input  fu_output_t        data_i,
  input  logic              pop_i,
  output fu_output_t        data_o,
  output logic [QCNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = wb_arb_idx_w(QDEPTH);
  typedef logic [PTR_W-1:0] ptr_t;

  fu_output_t        mem_q [QDEPTH];
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  logic [QCNT_W-1:0] count_q, count_d;
  logic              full_s, empty_s, do_push_s, do_pop_s;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(QDEPTH - 1)) ? ptr_t'(1'b0) : p + ptr_t'(1'b1);
  endfunction

  assign full_s    = (count_q == QCNT_W'(QDEPTH));
  assign empty_s   = (count_q == '0);
  assign do_push_s = push_i & ~full_s & ~flush_i;
  assign do_pop_s  = pop_i & ~empty_s & ~flush_i;

  // Pointer and occupancy next state; flush wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + QCNT_W'(1'b1);
        2'b01:   count_d = count_q - QCNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; only the written entry changes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin sharing of one write-back port among NR_REQ FU result streams.
// Optional WB_ARB_PERF_EN adds saturating stall/conflict performance counters.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ = NR_WB_REQ,
  parameter int unsigned QDEPTH = WB_QDEPTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  wb_port_arbiter_if.slave  bus
`ifdef WB_ARB_PERF_EN
  ,
  output wb_arb_cnt_t       perf_stall_o [NR_REQ],
  output wb_arb_cnt_t       perf_conflict_o
`endif
);

  localparam int unsigned IDX_W  = wb_arb_idx_w(NR_REQ);
  localparam int unsigned QCNT_W = $clog2(QDEPTH + 1);
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [NR_REQ-1:0] req_vec_t;

  fu_output_t        head_s  [NR_REQ];
  logic [QCNT_W-1:0] count_s [NR_REQ];
  req_vec_t          ready_s, nonempty_s, push_s, pop_s;
  logic              any_s, load_s, multi_s;
  idx_t              win_idx_s;

  fu_output_t wb_q, wb_d;
  logic       wb_valid_q, wb_valid_d;
  req_vec_t   grant_q, grant_d;
  idx_t       rr_ptr_q, rr_ptr_d;

  for (genvar g = 0; g < int'(NR_REQ); g++) begin : g_fifo
    wb_arb_fifo #(
      .QDEPTH (QDEPTH),
      .QCNT_W (QCNT_W)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .flush_i (flush_i),
      .push_i  (push_s[g]),
      .data_i  (bus.req_i[g]),
      .pop_i   (pop_s[g]),
      .data_o  (head_s[g]),
      .count_o (count_s[g])
    );
  end

  // Ready depends on stored occupancy only, so a full FIFO stays closed even when popped.
  always_comb begin
    ready_s    = '0;
    nonempty_s = '0;
    push_s     = '0;
    for (int r = 0; r < int'(NR_REQ); r++) begin
      ready_s[r]    = (count_s[r] != QCNT_W'(QDEPTH));
      nonempty_s[r] = (count_s[r] != '0);
      push_s[r]     = bus.req_i_valid[r] & ready_s[r];
    end
  end

  // Rotate-priority search: first non-empty FIFO at or after rr_ptr_q.
  always_comb begin
    win_idx_s = '0;
    any_s     = 1'b0;
    for (int k = 0; k < int'(NR_REQ); k++) begin
      int   sum;
      idx_t idx;
      logic hit;
      sum       = int'(rr_ptr_q) + k;
      sum       = (sum >= int'(NR_REQ)) ? sum - int'(NR_REQ) : sum;
      idx       = idx_t'(sum);
      hit       = ~any_s & nonempty_s[idx];
      win_idx_s = hit ? idx : win_idx_s;
      any_s     = any_s | hit;
    end
  end

  assign load_s  = (~wb_valid_q | bus.wb_o_ready) & any_s & ~flush_i;
  assign multi_s = ((nonempty_s & (nonempty_s - req_vec_t'(1'b1))) != '0);

  // Pop the winner on load; slot register next state (flush has priority).
  always_comb begin
    pop_s      = '0;
    wb_d       = wb_q;
    wb_valid_d = wb_valid_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    for (int r = 0; r < int'(NR_REQ); r++) begin
      pop_s[r] = load_s & (win_idx_s == idx_t'(r));
    end
    if (flush_i) begin
      wb_valid_d = 1'b0;
      grant_d    = '0;
    end else if (load_s) begin
      wb_d       = head_s[win_idx_s];
      wb_valid_d = 1'b1;
      grant_d    = req_vec_t'(1'b1) << win_idx_s;
      rr_ptr_d   = (win_idx_s == idx_t'(NR_REQ - 1)) ? idx_t'(1'b0)
                                                     : win_idx_s + idx_t'(1'b1);
    end else if (bus.wb_o_ready) begin
      wb_valid_d = 1'b0;
      grant_d    = '0;
    end else begin
      wb_valid_d = wb_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
    end else begin
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.req_i_ready = ready_s;
  assign bus.wb_o        = wb_q;
  assign bus.wb_o_valid  = wb_valid_q;
  assign bus.grant_o     = grant_q;

`ifdef WB_ARB_PERF_EN
  wb_arb_cnt_t stall_q [NR_REQ];
  wb_arb_cnt_t conflict_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < int'(NR_REQ); r++) begin
        stall_q[r] <= '0;
      end
      conflict_q <= '0;
    end else begin
      for (int r = 0; r < int'(NR_REQ); r++) begin
        stall_q[r] <= (bus.req_i_valid[r] & ~ready_s[r]) ? wb_arb_sat_inc(stall_q[r])
                                                         : stall_q[r];
      end
      conflict_q <= (load_s & multi_s) ? wb_arb_sat_inc(conflict_q) : conflict_q;
    end
  end

  assign perf_stall_o    = stall_q;
  assign perf_conflict_o = conflict_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int QD = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.NR_REQ(NR)) bus ();

`ifdef WB_ARB_PERF_EN
  wb_arb_cnt_t perf_stall [NR];
  wb_arb_cnt_t perf_conflict;
`endif

  wb_port_arbiter #(.NR_REQ(NR), .QDEPTH(QD)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (flush),
    .bus     (bus)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_stall_o    (perf_stall),
    .perf_conflict_o (perf_conflict)
`endif
  );

  // ---------------- reference model: per-source queues + one slot ----------------
  fu_output_t mq [NR][$];
  fu_output_t m_slot;
  logic       m_v;
  int         m_src;
  int         m_rr;

  task automatic model_reset();
    for (int r = 0; r < NR; r++) mq[r].delete();
    m_v = 1'b0; m_src = 0; m_rr = 0; m_slot = '0;
  endtask

  task automatic model_step();
    int  sz [NR];
    bit  any, free;
    if (!rstn) begin
      model_reset();
      return;
    end
    if (flush) begin
      for (int r = 0; r < NR; r++) mq[r].delete();
      m_v = 1'b0;
      return;
    end
    any = 0;
    for (int r = 0; r < NR; r++) begin
      sz[r] = mq[r].size();
      if (sz[r] > 0) any = 1;
    end
    free = !m_v || bus.wb_o_ready;
    if (free && any) begin
      for (int k = 0; k < NR; k++) begin
        int w = (m_rr + k) % NR;
        if (sz[w] > 0) begin
          m_slot = mq[w].pop_front();
          m_v    = 1'b1;
          m_src  = w;
          m_rr   = (w + 1) % NR;
          break;
        end
      end
    end else if (free) begin
      m_v = 1'b0;
    end
    for (int r = 0; r < NR; r++)
      if (bus.req_i_valid[r] && sz[r] != QD) mq[r].push_back(bus.req_i[r]);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [NR-1:0] g, rdy;
    g = '0;
    rdy = '0;
    if (m_v) g[m_src] = 1'b1;
    for (int r = 0; r < NR; r++) rdy[r] = (mq[r].size() != QD);
    chk("model_valid", 64'(bus.wb_o_valid), 64'(m_v));
    chk("model_grant", 64'(bus.grant_o), 64'(g));
    chk("model_ready", 64'(bus.req_i_ready), 64'(rdy));
    if (m_v) chk("model_data", 64'(bus.wb_o), 64'(m_slot));
  endtask

  // Inputs are set at posedge+1; the model consumes them, then the edge happens.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic fu_output_t mk(input logic [3:0] id, input logic [31:0] res);
    fu_output_t f;
    f.result = res;
    f.trans_id = id;
    f.ex_valid = 1'b0;
    return f;
  endfunction

  task automatic drive(input logic [NR-1:0] v, input logic [3:0] id, input logic wr);
    bus.req_i_valid = v;
    bus.wb_o_ready  = wr;
    for (int r = 0; r < NR; r++) bus.req_i[r] = mk(id, 32'(r));
  endtask

  task automatic do_reset();
    drive('0, 4'd0, 1'b0);
    flush = 1'b0;
    rstn  = 1'b0;
    step();
    rstn  = 1'b1;
  endtask

  typedef struct {
    logic [NR-1:0] v;
    logic [3:0]    id;
    logic          wbr;
    logic          fl;
    logic          exp_v;
    logic [NR-1:0] exp_g;
    logic [3:0]    exp_id;
    logic [NR-1:0] exp_rdy;
  } vec_t;

  vec_t tbl [15];
  int   gcnt [NR];

  initial begin
    // Single-source stream, backpressure on one source, then a flush that drops a buffered id.
    tbl[0]  = '{3'b010, 4'd5,  1'b1, 1'b0, 1'b0, 3'b000, 4'd0, 3'b111};
    tbl[1]  = '{3'b010, 4'd6,  1'b1, 1'b0, 1'b1, 3'b010, 4'd5, 3'b111};
    tbl[2]  = '{3'b010, 4'd7,  1'b1, 1'b0, 1'b1, 3'b010, 4'd6, 3'b111};
    tbl[3]  = '{3'b000, 4'd0,  1'b1, 1'b0, 1'b1, 3'b010, 4'd7, 3'b111};
    tbl[4]  = '{3'b000, 4'd0,  1'b1, 1'b0, 1'b0, 3'b000, 4'd0, 3'b111};
    tbl[5]  = '{3'b001, 4'd1,  1'b0, 1'b0, 1'b0, 3'b000, 4'd0, 3'b111};
    tbl[6]  = '{3'b001, 4'd2,  1'b0, 1'b0, 1'b1, 3'b001, 4'd1, 3'b111};
    tbl[7]  = '{3'b001, 4'd3,  1'b0, 1'b0, 1'b1, 3'b001, 4'd1, 3'b110};
    tbl[8]  = '{3'b001, 4'd4,  1'b0, 1'b0, 1'b1, 3'b001, 4'd1, 3'b110};
    tbl[9]  = '{3'b000, 4'd0,  1'b1, 1'b0, 1'b1, 3'b001, 4'd2, 3'b111};
    tbl[10] = '{3'b000, 4'd0,  1'b1, 1'b0, 1'b1, 3'b001, 4'd3, 3'b111};
    tbl[11] = '{3'b000, 4'd0,  1'b1, 1'b0, 1'b0, 3'b000, 4'd0, 3'b111};
    tbl[12] = '{3'b100, 4'd9,  1'b0, 1'b0, 1'b0, 3'b000, 4'd0, 3'b111};
    tbl[13] = '{3'b100, 4'd10, 1'b0, 1'b1, 1'b0, 3'b000, 4'd0, 3'b111};
    tbl[14] = '{3'b000, 4'd0,  1'b1, 1'b0, 1'b0, 3'b000, 4'd0, 3'b111};

    model_reset();
    drive(3'b111, 4'd0, 1'b0);
    rstn = 1'b0;
    repeat (3) step();
    chk("reset_valid", 64'(bus.wb_o_valid), 64'd0);
    chk("reset_grant", 64'(bus.grant_o), 64'd0);
    drive('0, 4'd0, 1'b0);
    rstn = 1'b1;
    #1;
    chk("reset_ready", 64'(bus.req_i_ready), 64'(3'b111));

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].id, tbl[i].wbr);
      flush = tbl[i].fl;
      step();
      flush = 1'b0;
      chk($sformatf("tbl%0d_valid", i), 64'(bus.wb_o_valid), 64'(tbl[i].exp_v));
      chk($sformatf("tbl%0d_grant", i), 64'(bus.grant_o), 64'(tbl[i].exp_g));
      chk($sformatf("tbl%0d_ready", i), 64'(bus.req_i_ready), 64'(tbl[i].exp_rdy));
      if (tbl[i].exp_v)
        chk($sformatf("tbl%0d_id", i), 64'(bus.wb_o.trans_id), 64'(tbl[i].exp_id));
    end

    // Fairness: all sources always valid, port always ready.
    do_reset();
    drive(3'b111, 4'd0, 1'b1);
    for (int r = 0; r < NR; r++) gcnt[r] = 0;
    step();
    for (int k = 0; k < 30; k++) begin
      step();
      chk("fair_seq", 64'(bus.grant_o), 64'(3'b001 << (k % 3)));
      for (int r = 0; r < NR; r++) if (bus.grant_o[r]) gcnt[r]++;
    end
    for (int r = 0; r < NR; r++) chk("fair_share", 64'(gcnt[r]), 64'd10);

    // Backpressure: source 0 overfills while the port stalls.
    do_reset();
    drive(3'b001, 4'd1, 1'b0); step();
    drive(3'b001, 4'd2, 1'b0); step();
    drive(3'b001, 4'd3, 1'b0); step();
    chk("bp_ready0", 64'(bus.req_i_ready[0]), 64'd0);
    for (int k = 0; k < 10; k++) begin
      drive(3'b001, 4'd4, 1'b0);
      step();
      chk("bp_stable", 64'(bus.wb_o.trans_id), 64'd1);
    end
    chk("bp_valid", 64'(bus.wb_o_valid), 64'd1);
`ifdef WB_ARB_PERF_EN
    chk("perf_stall0", 64'(perf_stall[0]), 64'd10);
    chk("perf_stall1", 64'(perf_stall[1]), 64'd0);
    chk("perf_stall2", 64'(perf_stall[2]), 64'd0);
    chk("perf_conflict", 64'(perf_conflict), 64'd0);
`endif
    drive('0, 4'd0, 1'b1); step();
    chk("bp_drain1", 64'(bus.wb_o.trans_id), 64'd2);
    step();
    chk("bp_drain2", 64'(bus.wb_o.trans_id), 64'd3);
    step();
    chk("bp_empty", 64'(bus.wb_o_valid), 64'd0);

    // Flush with four buffered results plus an occupied slot.
    do_reset();
    drive(3'b011, 4'd8, 1'b0); step();
    drive(3'b011, 4'd9, 1'b0); step();
    drive(3'b001, 4'd10, 1'b0); step();
    chk("fl_pre_ready", 64'(bus.req_i_ready), 64'(3'b100));
    drive(3'b011, 4'd11, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("fl_valid", 64'(bus.wb_o_valid), 64'd0);
    chk("fl_ready", 64'(bus.req_i_ready), 64'(3'b111));
    drive('0, 4'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fl_no_stale", 64'(bus.wb_o_valid), 64'd0);
    end

    // Asynchronous reset between edges discards everything immediately.
    drive(3'b111, 4'd12, 1'b0); step(); step();
    chk("ar_pre_valid", 64'(bus.wb_o_valid), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.wb_o_valid), 64'd0);
    chk("ar_grant", 64'(bus.grant_o), 64'd0);
    @(posedge clk); #1;
    model_reset();
    drive('0, 4'd0, 1'b1);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ar_no_stale", 64'(bus.wb_o_valid), 64'd0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bus.req_i_valid = NR'($urandom);
      bus.wb_o_ready  = ($urandom_range(0, 9) < 7);
      flush           = ($urandom_range(0, 63) == 0);
      for (int r = 0; r < NR; r++) bus.req_i[r] = mk(4'($urandom), $urandom);
      step();
      model_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
